// File: rtl/m_store_buf_pkg.sv
// Shared definitions for the store buffer: op encodings, byte-enable
// constants, default depth and the buffered entry layout.
package m_store_buf_pkg;

  localparam int DEFAULT_DEPTH = 4;

  typedef enum logic [1:0] {
    OP_SW  = 2'b00,
    OP_SH  = 2'b01,
    OP_SB  = 2'b10,
    OP_ILL = 2'b11
  } st_op_e;

  localparam logic [3:0] BE_NONE    = 4'b0000;
  localparam logic [3:0] BE_WORD    = 4'b1111;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_BYTE0   = 4'b0001;

  // One buffered store; the address is kept word-aligned, so only [31:2].
  typedef struct packed {
    logic [29:0] word_addr;
    logic [31:0] data;
    logic [3:0]  byteen;
  } sb_entry_t;

endpackage

// File: rtl/m_st_fmt.sv
// Store lane formatter: turns (op, low address bits, register data) into
// memory byte enables and lane-replicated write data, and flags misalignment.
module m_st_fmt
  import m_store_buf_pkg::*;
(
  input  logic [1:0]  op,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  output logic [3:0]  byteen,
  output logic [31:0] data,
  output logic        misaligned,
  output logic        enqueue
);

  st_op_e op_e;
  assign op_e = st_op_e'(op);

  // Decode the access size into lane enables and replicated data.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    byteen     = BE_NONE;
    data       = wdata;
    misaligned = 1'b0;
    case (op_e)
      OP_SW: begin
        byteen     = BE_WORD;
        data       = wdata;
        misaligned = (addr_lo != 2'b00);
      end
      OP_SH: begin
        byteen     = addr_lo[1] ? BE_HALF_HI : BE_HALF_LO;
        data       = {2{wdata[15:0]}};
        misaligned = addr_lo[0];
      end
      OP_SB: begin
        byteen = BE_BYTE0 << addr_lo;
        data   = {4{wdata[7:0]}};
      end
      default: ;
    endcase
    // Illegal ops and misaligned stores are consumed but never buffered.
    enqueue = (op_e != OP_ILL) && !misaligned;
  end

endmodule

// File: rtl/m_store_buf.sv
// In-order store buffer between the memory stage and data memory. Stores
// are formatted on entry, drained from the head one per DM handshake, and
// a load in the same stage can ask whether any buffered store hits its word.
module m_store_buf
  import m_store_buf_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH
)
(
  input  logic        clk,
  input  logic        reset,
  input  logic        M_st_valid,
  input  logic [1:0]  M_st_op,
  input  logic [31:0] M_st_addr,
  input  logic [31:0] M_st_wdata,
  output logic        M_st_ready,
  output logic        M_st_excp,
  input  logic [31:0] M_ld_addr,
  output logic        M_ld_hit,
  output logic        DM_valid,
  output logic [31:0] DM_addr,
  output logic [31:0] DM_wdata,
  output logic [3:0]  DM_byteen,
  input  logic        DM_ready,
  output logic [3:0]  M_buf_count
);

  localparam int         PW   = $clog2(DEPTH);
  localparam logic [3:0] FULL = 4'(DEPTH);

  sb_entry_t        mem [DEPTH];
  sb_entry_t        head;
  logic [DEPTH-1:0] valid;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [3:0]       count;
  logic             excp_q;

  logic [3:0]       fmt_byteen;
  logic [31:0]      fmt_data;
  logic             fmt_mis;
  logic             fmt_enq;
  logic             take;
  logic             push;
  logic             pop;
  logic             unused_ld_lo;

  m_st_fmt u_fmt (
    .op         (M_st_op),
    .addr_lo    (M_st_addr[1:0]),
    .wdata      (M_st_wdata),
    .byteen     (fmt_byteen),
    .data       (fmt_data),
    .misaligned (fmt_mis),
    .enqueue    (fmt_enq)
  );

  // Ready depends only on occupancy, never on DM_ready, so a full buffer
  // refuses a request even in a cycle where it also pops.
  assign M_st_ready = (count != FULL);
  assign take       = M_st_valid && M_st_ready;
  assign push       = take && fmt_enq;
  assign DM_valid   = (count != 4'd0);
  assign pop        = DM_valid && DM_ready;

  // Pointers, occupancy, per-entry valid bits and the exception pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      valid  <= '0;
      excp_q <= 1'b0;
    end else begin
      // NOTE: state is updated with non-blocking assignments so every read sees pre-edge values.
      if (push) begin
        wr_ptr        <= wr_ptr + 1'b1;
        valid[wr_ptr] <= 1'b1;
      end
      if (pop) begin
        rd_ptr        <= rd_ptr + 1'b1;
        valid[rd_ptr] <= 1'b0;
      end
      count  <= count + {3'b000, push} - {3'b000, pop};
      excp_q <= take && fmt_mis;
    end
  end

  // Entry storage, written at the tail on every enqueue.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: the storage is reset because the head drives DM_* directly and must read zero in reset.
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push) begin
      mem[wr_ptr] <= '{word_addr: M_st_addr[31:2], data: fmt_data, byteen: fmt_byteen};
    end
  end

  // Head entry straight from storage: stable while the memory stalls.
  assign head        = mem[rd_ptr];
  assign DM_addr     = {head.word_addr, 2'b00};
  assign DM_wdata    = head.data;
  assign DM_byteen   = head.byteen;
  assign M_st_excp   = excp_q;
  assign M_buf_count = count;

  // Word-granular load hit against every valid entry, byte enables ignored.
  always_comb begin
    M_ld_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid[i] && (mem[i].word_addr == M_ld_addr[31:2])) M_ld_hit = 1'b1;
    end
  end

  // Byte offset of the load address does not matter for a word match.
  assign unused_ld_lo = ^M_ld_addr[1:0];

endmodule

// File: tb/tb_m_store_buf.sv
// Self-checking bench for m_store_buf: directed scenarios with literal
// expectations, then randomized traffic compared every cycle against a
// queue-based model of the store buffer.
module tb_m_store_buf;

  localparam int DEPTH = 4;

  logic        clk;
  logic        reset;
  logic        M_st_valid;
  logic [1:0]  M_st_op;
  logic [31:0] M_st_addr;
  logic [31:0] M_st_wdata;
  logic        M_st_ready;
  logic        M_st_excp;
  logic [31:0] M_ld_addr;
  logic        M_ld_hit;
  logic        DM_valid;
  logic [31:0] DM_addr;
  logic [31:0] DM_wdata;
  logic [3:0]  DM_byteen;
  logic        DM_ready;
  logic [3:0]  M_buf_count;

  m_store_buf #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .M_st_valid  (M_st_valid),
    .M_st_op     (M_st_op),
    .M_st_addr   (M_st_addr),
    .M_st_wdata  (M_st_wdata),
    .M_st_ready  (M_st_ready),
    .M_st_excp   (M_st_excp),
    .M_ld_addr   (M_ld_addr),
    .M_ld_hit    (M_ld_hit),
    .DM_valid    (DM_valid),
    .DM_addr     (DM_addr),
    .DM_wdata    (DM_wdata),
    .DM_byteen   (DM_byteen),
    .DM_ready    (DM_ready),
    .M_buf_count (M_buf_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } exp_t;

  exp_t q[$];
  logic exp_excp = 1'b0;

  // Store formatting from first principles: an access of `size` bytes
  // covers the aligned lanes containing the address; each lane carries the
  // register byte at (lane mod size).
  function automatic void fmt_model(input logic [1:0] op, input logic [31:0] a,
                                    input logic [31:0] w, output logic [3:0] be,
                                    output logic [31:0] d, output bit mis, output bit enq);
    int lo, size, base;
    lo   = int'(a[1:0]);
    size = (op == 2'd0) ? 4 : (op == 2'd1) ? 2 : 1;
    mis  = (op != 2'd3) && ((lo % size) != 0);
    enq  = (op != 2'd3) && !mis;
    base = lo - (lo % size);
    be   = 4'b0000;
    d    = 32'h0;
    for (int i = 0; i < 4; i++) begin
      if (i >= base && i < base + size) be[i] = 1'b1;
      d[8*i +: 8] = w[8*(i % size) +: 8];
    end
  endfunction

  // Model state advance on each rising edge; reset clears it at once.
  initial begin
    bit          m_acc, m_pop, m_mis, m_enq;
    logic [3:0]  m_be;
    logic [31:0] m_data;
    exp_t        e;
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) begin
        q.delete();
        exp_excp = 1'b0;
      end else begin
        m_acc = M_st_valid && (q.size() < DEPTH);
        m_pop = (q.size() != 0) && DM_ready;
        if (m_pop) void'(q.pop_front());
        exp_excp = 1'b0;
        if (m_acc) begin
          fmt_model(M_st_op, M_st_addr, M_st_wdata, m_be, m_data, m_mis, m_enq);
          if (m_mis) exp_excp = 1'b1;
          else if (m_enq) begin
            e.addr = {M_st_addr[31:2], 2'b00};
            e.data = m_data;
            e.be   = m_be;
            q.push_back(e);
          end
        end
      end
    end
  end

  // Every-cycle comparison against the model, mid-cycle on the falling edge.
  task automatic compare();
    bit hit;
    if (!reset) begin
      check("rst_ready",    32'(M_st_ready),  32'd1);
      check("rst_count",    32'(M_buf_count), 32'd0);
      check("rst_dm_valid", 32'(DM_valid),    32'd0);
      check("rst_dm_addr",  DM_addr,          32'd0);
      check("rst_dm_wdata", DM_wdata,         32'd0);
      check("rst_dm_be",    32'(DM_byteen),   32'd0);
      check("rst_excp",     32'(M_st_excp),   32'd0);
      check("rst_hit",      32'(M_ld_hit),    32'd0);
    end else begin
      check("ready",    32'(M_st_ready),  32'(q.size() < DEPTH));
      check("count",    32'(M_buf_count), 32'(q.size()));
      check("dm_valid", 32'(DM_valid),    32'(q.size() != 0));
      if (q.size() != 0) begin
        check("dm_addr",  DM_addr,        q[0].addr);
        check("dm_wdata", DM_wdata,       q[0].data);
        check("dm_be",    32'(DM_byteen), 32'(q[0].be));
      end
      check("excp", 32'(M_st_excp), 32'(exp_excp));
      hit = 1'b0;
      foreach (q[i]) if (q[i].addr[31:2] == M_ld_addr[31:2]) hit = 1'b1;
      check("ld_hit", 32'(M_ld_hit), 32'(hit));
    end
  endtask

  initial forever begin
    @(negedge clk);
    compare();
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic set_req(input logic v, input logic [1:0] op, input logic [31:0] a, input logic [31:0] w);
    M_st_valid = v;
    M_st_op    = op;
    M_st_addr  = a;
    M_st_wdata = w;
  endtask

  initial begin
    int hs;
    logic [31:0] sw_addr [4];
    sw_addr[0] = 32'h0; sw_addr[1] = 32'h4; sw_addr[2] = 32'h8; sw_addr[3] = 32'hC;

    reset = 1'b0;
    set_req(1'b0, 2'b00, 32'h0, 32'h0);
    M_ld_addr = 32'h0;
    DM_ready  = 1'b0;
    repeat (2) cyc();
    at_neg();
    check("p_rst_ready", 32'(M_st_ready),  32'd1);
    check("p_rst_count", 32'(M_buf_count), 32'd0);
    cyc();
    reset = 1'b1;

    // SB to byte 3 of word 0x1000, memory always ready.
    set_req(1'b1, 2'b10, 32'h0000_1003, 32'h0000_00A5);
    DM_ready = 1'b1;
    cyc();
    M_st_valid = 1'b0;
    at_neg();
    check("p_sb_valid", 32'(DM_valid),    32'd1);
    check("p_sb_addr",  DM_addr,          32'h0000_1000);
    check("p_sb_be",    32'(DM_byteen),   32'b1000);
    check("p_sb_data",  DM_wdata,         32'hA5A5_A5A5);
    cyc();
    at_neg();
    check("p_sb_drain", 32'(M_buf_count), 32'd0);

    // SH upper half, then a misaligned SH.
    DM_ready = 1'b0;
    set_req(1'b1, 2'b01, 32'h0000_2002, 32'h0000_1234);
    cyc();
    M_st_addr = 32'h0000_2001;
    at_neg();
    check("p_sh_be",   32'(DM_byteen), 32'b1100);
    check("p_sh_data", DM_wdata,       32'h1234_1234);
    check("p_sh_addr", DM_addr,        32'h0000_2000);
    cyc();
    M_st_valid = 1'b0;
    at_neg();
    check("p_mis_excp",  32'(M_st_excp),   32'd1);
    check("p_mis_count", 32'(M_buf_count), 32'd1);
    cyc();
    at_neg();
    check("p_mis_pulse", 32'(M_st_excp), 32'd0);
    DM_ready = 1'b1;
    cyc();
    DM_ready = 1'b0;
    at_neg();
    check("p_sh_drain", 32'(M_buf_count), 32'd0);

    // Fill with four SW while memory stalls; a fifth waits.
    for (int i = 0; i < 4; i++) begin
      set_req(1'b1, 2'b00, sw_addr[i], sw_addr[i] + 32'h100);
      cyc();
    end
    set_req(1'b1, 2'b00, 32'h10, 32'h110);
    cyc();
    at_neg();
    check("p_full_ready", 32'(M_st_ready),  32'd0);
    check("p_full_count", 32'(M_buf_count), 32'd4);
    check("p_full_head",  DM_addr,          32'h0);
    cyc();
    at_neg();
    check("p_full_held", 32'(M_buf_count), 32'd4);
    DM_ready = 1'b1;
    cyc();
    at_neg();
    check("p_poponly_count", 32'(M_buf_count), 32'd3);
    check("p_poponly_head",  DM_addr,          32'h4);
    check("p_poponly_ready", 32'(M_st_ready),  32'd1);
    cyc();
    M_st_valid = 1'b0;
    at_neg();
    check("p_pushpop_count", 32'(M_buf_count), 32'd3);
    check("p_pushpop_head",  DM_addr,          32'h8);
    cyc();
    at_neg();
    check("p_order_c", DM_addr, 32'hC);
    cyc();
    at_neg();
    check("p_order_10",  DM_addr,  32'h10);
    check("p_order_10d", DM_wdata, 32'h110);
    cyc();
    at_neg();
    check("p_order_empty", 32'(M_buf_count), 32'd0);
    DM_ready = 1'b0;

    // Load hit against a buffered SW to 0x40.
    set_req(1'b1, 2'b00, 32'h40, 32'hDEAD_BEEF);
    cyc();
    M_st_valid = 1'b0;
    M_ld_addr  = 32'h43;
    at_neg();
    check("p_hit_43", 32'(M_ld_hit), 32'd1);
    cyc();
    M_ld_addr = 32'h44;
    at_neg();
    check("p_hit_44", 32'(M_ld_hit), 32'd0);

    // Reset in the middle of a stalled drain with three entries queued.
    set_req(1'b1, 2'b00, 32'h50, 32'h5);
    cyc();
    M_st_addr = 32'h60;
    cyc();
    M_st_valid = 1'b0;
    at_neg();
    check("p_pre_rst_count", 32'(M_buf_count), 32'd3);
    cyc();
    #2;
    reset     = 1'b0;
    M_ld_addr = 32'h40;
    #1;
    check("p_mid_rst_valid", 32'(DM_valid),    32'd0);
    check("p_mid_rst_count", 32'(M_buf_count), 32'd0);
    check("p_mid_rst_hit",   32'(M_ld_hit),    32'd0);
    check("p_mid_rst_ready", 32'(M_st_ready),  32'd1);
    at_neg();
    cyc();
    reset    = 1'b1;
    DM_ready = 1'b1;
    hs = 0;
    repeat (5) begin
      at_neg();
      if (DM_valid) hs++;
    end
    check("p_no_hs_after_rst", 32'(hs), 32'd0);
    DM_ready = 1'b0;

    // Randomized traffic; memory readiness bias changes every 200 cycles.
    for (int n = 0; n < 3000; n++) begin
      int ready_pct;
      cyc();
      ready_pct  = ((n / 200) % 3 == 0) ? 20 : ((n / 200) % 3 == 1) ? 50 : 85;
      M_st_valid = ($urandom_range(0, 99) < 60);
      M_st_op    = 2'($urandom_range(0, 3));
      M_st_addr  = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 63));
      M_st_wdata = $urandom;
      M_ld_addr  = 32'($urandom_range(0, 63));
      DM_ready   = ($urandom_range(0, 99) < ready_pct);
      if ($urandom_range(0, 299) == 0) begin
        reset = 1'b0;
        #6;
        reset = 1'b1;
      end
    end
    cyc();
    M_st_valid = 1'b0;
    at_neg();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/m_store_buf.md
M_STORE_BUF -- requirements
Module: m_store_buf

Interface
REQ-001 Parameter: DEPTH, default 4, number of store-buffer entries (power of two, 2..8).
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 M_st_valid  input  1  store request present this cycle.
REQ-005 M_st_op  input  2  00 SW, 01 SH, 10 SB, 11 illegal.
REQ-006 M_st_addr  input  32  byte address of the store.
REQ-007 M_st_wdata  input  32  register data, value in low bits.
REQ-008 M_st_ready  output  1  buffer can accept a request.
REQ-009 M_st_excp  output  1  one-cycle pulse: previous accepted request was misaligned.
REQ-010 M_ld_addr  input  32  address of a load in the same stage.
REQ-011 M_ld_hit  output  1  a buffered store targets the same word as M_ld_addr.
REQ-012 DM_valid  output  1  head entry presented to data memory.
REQ-013 DM_addr  output  32  word-aligned write address.
REQ-014 DM_wdata  output  32  lane-placed write data.
REQ-015 DM_byteen  output  4  per-byte write enables.
REQ-016 DM_ready  input  1  memory accepts the head entry this cycle.
REQ-017 M_buf_count  output  4  number of valid entries, 0..DEPTH.

Function
REQ-018 Handshake: a request is taken when M_st_valid && M_st_ready on a rising edge; M_st_ready SHALL equal (count != DEPTH), with no combinational path from DM_ready.
REQ-019 Misalignment: SW with addr[1:0]!=0 or SH with addr[0]!=0 SHALL be taken but not enqueued, and M_st_excp SHALL be 1 for exactly the next cycle.
REQ-020 Op 11 SHALL be taken, not enqueued, and SHALL NOT raise M_st_excp.
REQ-021 SW: byteen 1111, data = wdata.
REQ-022 SH: byteen 0011 if addr[1]=0, else 1100; data = {2{wdata[15:0]}}.
REQ-023 SB: byteen = 0001 << addr[1:0]; data = {4{wdata[7:0]}}.
REQ-024 Stored address SHALL be {addr[31:2],2'b00}.
REQ-025 Drain: DM_valid = (count != 0); DM_addr/wdata/byteen SHALL come from the head entry, registered, and stay stable while DM_valid && !DM_ready.
REQ-026 Pop on DM_valid && DM_ready; entries drain strictly in acceptance order.
REQ-027 Latency: a store enqueued at edge N into an empty buffer SHALL appear on DM_valid in the cycle after edge N (no bypass).
REQ-028 Simultaneous push and pop SHALL leave count unchanged, with both operations completing.
REQ-029 Full: while count == DEPTH, M_st_ready=0 even if DM_ready=1 in the same cycle.
REQ-030 Pointers SHALL wrap modulo DEPTH; count SHALL never exceed DEPTH or underflow.
REQ-031 M_ld_hit SHALL be combinational: 1 iff any valid entry has address[31:2] == M_ld_addr[31:2], regardless of byteen.

Reset
REQ-032 On reset low, all entries SHALL be invalidated immediately; pointers and count go to 0.
REQ-033 During reset, the outputs SHALL be: DM_valid=0, DM_addr=0, DM_wdata=0, DM_byteen=0, M_st_excp=0, M_ld_hit=0, M_buf_count=0, M_st_ready=1.
REQ-034 A reset during a stalled drain SHALL discard the entry; no write completes afterwards.

Structure
REQ-035 Shared package: op encodings (SW/SH/SB/ILL), byteen constants, default DEPTH.
REQ-036 Lane formatting (op, addr, wdata -> byteen, data, misaligned) SHALL be a combinational sub-module m_st_fmt; the FIFO and hit logic stay in m_store_buf.

Verification
REQ-037 SB, addr 0x1003, wdata 0x000000A5, DM_ready=1 -> next cycle DM_addr 0x1000, byteen 1000, wdata 0xA5A5A5A5; count returns to 0.
REQ-038 SH, addr 0x2002, wdata 0x1234 -> byteen 1100, wdata 0x12341234; SH to 0x2001 -> M_st_excp pulses one cycle, count unchanged.
REQ-039 DM_ready=0, five SW to 0x0,0x4,0x8,0xC,0x10 -> the first four are taken, M_st_ready=0 at count 4, the fifth is held; releasing DM_ready drains in order, then the fifth is accepted.
REQ-040 At count 4, raise DM_ready with a new request pending -> pop only, count 3, request accepted next cycle.
REQ-041 Buffer holds SW 0x40; M_ld_addr 0x43 -> M_ld_hit=1; M_ld_addr 0x44 -> 0.
REQ-042 Three entries queued, DM_ready=0, assert reset mid-cycle -> DM_valid drops immediately, count 0, no DM handshake after release.
